// File: rtl/mem_responder.sv
// mem_responder: fixed-latency line-memory responder.
// Each accepted request reads or writes one line of a local backing store on
// the handshake edge. The request then travels down a MEM_STAGES-deep pipeline
// whose last stage presents the response. A response the consumer refuses
// freezes the whole pipeline and blocks new requests until it is taken.

module mem_responder #(
    parameter int PA_WIDTH   = 32,
    parameter int LINE_WIDTH = 128,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_STAGES = 5,
    parameter int MEM_LINES  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [PA_WIDTH-1:0]   req_addr,
    input  logic [LINE_WIDTH-1:0] req_wdata,
    input  logic [ID_WIDTH-1:0]   req_id,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [LINE_WIDTH-1:0] rsp_rdata,
    output logic [ID_WIDTH-1:0]   rsp_id,
    output logic                  busy
);

    localparam int IDX_W = $clog2(MEM_LINES);

    // One pipeline slot: a request, or a bubble with every field zero.
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [ID_WIDTH-1:0]   id;
        logic [LINE_WIDTH-1:0] data;
    } stage_t;

    logic [LINE_WIDTH-1:0] mem [MEM_LINES];
    stage_t                pipe [MEM_STAGES];
    stage_t                entry;
    logic [IDX_W-1:0]      line_idx;
    logic                  stall;
    logic                  accept;
    logic                  unused_addr;

    // Lines are 16 bytes, so the byte offset and the bits above the index
    // never select anything.
    assign line_idx    = req_addr[4 +: IDX_W];
    assign unused_addr = ^{req_addr[3:0], req_addr[PA_WIDTH-1:4+IDX_W]};

    // A response held by the consumer freezes every stage.
    assign stall     = pipe[MEM_STAGES-1].valid && !rsp_ready;
    assign req_ready = !stall;
    assign accept    = req_valid && req_ready;

    // Build the stage-0 entry; idle cycles insert an all-zero bubble so
    // request inputs never leak into rsp_* while req_valid is low.
    always_comb begin
        // NOTE: every field gets a default before any branch, so no latch is inferred.
        entry = '0;
        if (req_valid) begin
            entry.valid = 1'b1;
            entry.we    = req_we;
            entry.id    = req_id;
            if (!req_we) begin
                entry.data = mem[line_idx];
            end
        end
    end

    // Backing store: whole-line write on the handshake edge.
    // NOTE: the store has no reset; its contents must survive rst_n and a
    // resettable array would also stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (accept && req_we) begin
            mem[line_idx] <= req_wdata;
        end
    end

    // Shift every stage one step per unstalled cycle; reset drops in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_STAGES; i++) begin
                // NOTE: state updates use <= so every stage samples its
                // predecessor's old value and the shift does not collapse.
                pipe[i] <= '0;
            end
        end else if (!stall) begin
            pipe[0] <= entry;
            for (int i = 1; i < MEM_STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Busy whenever any stage holds a request.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < MEM_STAGES; i++) begin
            busy = busy | pipe[i].valid;
        end
    end

    assign rsp_valid = pipe[MEM_STAGES-1].valid;
    assign rsp_we    = pipe[MEM_STAGES-1].we;
    assign rsp_id    = pipe[MEM_STAGES-1].id;
    assign rsp_rdata = pipe[MEM_STAGES-1].data;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios plus randomized traffic for
// mem_responder, checked every cycle against a scoreboard that tracks each
// request's age in unstalled cycles rather than modelling stage registers.

module tb_mem_responder;

    localparam int PA_WIDTH   = 32;
    localparam int LINE_WIDTH = 128;
    localparam int ID_WIDTH   = 4;
    localparam int MEM_STAGES = 5;
    localparam int MEM_LINES  = 256;
    localparam int IDX_W      = $clog2(MEM_LINES);

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [PA_WIDTH-1:0]   req_addr;
    logic [LINE_WIDTH-1:0] req_wdata;
    logic [ID_WIDTH-1:0]   req_id;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_we;
    logic [LINE_WIDTH-1:0] rsp_rdata;
    logic [ID_WIDTH-1:0]   rsp_id;
    logic                  busy;

    mem_responder #(
        .PA_WIDTH  (PA_WIDTH),
        .LINE_WIDTH(LINE_WIDTH),
        .ID_WIDTH  (ID_WIDTH),
        .MEM_STAGES(MEM_STAGES),
        .MEM_LINES (MEM_LINES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_id   (req_id),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_we   (rsp_we),
        .rsp_rdata(rsp_rdata),
        .rsp_id   (rsp_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [LINE_WIDTH-1:0] act,
                         input logic [LINE_WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each accepted request is stamped with the advance count at its
    // acceptance; it is presented once MEM_STAGES-1 further unstalled edges
    // have passed and stays presented until taken.
    typedef struct {
        bit                    we;
        logic [ID_WIDTH-1:0]   id;
        logic [LINE_WIDTH-1:0] data;
        int unsigned           tag;
    } exp_t;

    exp_t                  q[$];
    int unsigned           adv = 0;
    logic [LINE_WIDTH-1:0] mm [MEM_LINES];
    bit                    known [MEM_LINES];

    function automatic bit head_present();
        if (q.size() == 0) return 1'b0;
        return (adv - q[0].tag) == MEM_STAGES - 1;
    endfunction

    function automatic logic [LINE_WIDTH-1:0] pattern(input int k);
        return {16{8'(k + 16)}};
    endfunction

    // Model update on each edge, using the inputs the DUT samples.
    always @(posedge clk) begin
        logic pres;
        exp_t e;
        int   idx;
        if (rst_n) begin
            pres = head_present();
            if (!(pres && !rsp_ready)) begin
                if (pres) void'(q.pop_front());
                adv++;
                if (req_valid) begin
                    idx    = int'(req_addr[4 +: IDX_W]);
                    e.we   = req_we;
                    e.id   = req_id;
                    e.tag  = adv;
                    e.data = req_we ? '0 : mm[idx];
                    q.push_back(e);
                    if (req_we) begin
                        mm[idx]    = req_wdata;
                        known[idx] = 1'b1;
                    end
                end
            end
        end
    end

    // Reset throws away everything in flight.
    always @(negedge rst_n) q.delete();

    // Per-cycle comparison, half a cycle away from the active edge.
    always @(negedge clk) begin
        logic pres;
        if (!rst_n) begin
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_req_ready", req_ready, 1);
            check("rst_rsp_we", rsp_we, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
        end else begin
            pres = head_present();
            check("rsp_valid", rsp_valid, pres);
            check("busy", busy, q.size() != 0);
            check("req_ready", req_ready, !(pres && !rsp_ready));
            if (pres) begin
                check("rsp_we", rsp_we, q[0].we);
                check("rsp_id", rsp_id, q[0].id);
                check("rsp_rdata", rsp_rdata, q[0].data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input bit we, input logic [PA_WIDTH-1:0] addr,
                         input logic [LINE_WIDTH-1:0] wdata, input logic [ID_WIDTH-1:0] id);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_id    = id;
    endtask

    // Idle cycles carry junk on the request fields; it must be ignored.
    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        req_id    = ID_WIDTH'($urandom);
    endtask

    task automatic drain();
        idle();
        rsp_ready = 1'b1;
        repeat (MEM_STAGES + 3) cyc();
    endtask

    task automatic wait_rsp(output logic [ID_WIDTH-1:0] id, output logic we,
                            output logic [LINE_WIDTH-1:0] data);
        bit ok = 1'b0;
        id = '0; we = 1'b0; data = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                id = rsp_id; we = rsp_we; data = rsp_rdata; ok = 1'b1;
                break;
            end
        end
        check("wait_rsp_timeout", ok, 1);
    endtask

    // ---------------- directed scenarios ----------------
    task automatic t_write_then_read();
        // Cycle t: write offered in the first cycle out of reset.
        offer(1'b1, 32'h40, {16{8'hA5}}, 4'd3);
        cyc();
        offer(1'b0, 32'h40, '0, 4'd4);
        cyc();
        idle();
        repeat (2) cyc();
        @(negedge clk);
        check("wr_rd_t4_idle", rsp_valid, 0);
        cyc();
        @(negedge clk);
        check("wr_ack_valid", rsp_valid, 1);
        check("wr_ack_we", rsp_we, 1);
        check("wr_ack_id", rsp_id, 3);
        check("wr_ack_rdata", rsp_rdata, 0);
        cyc();
        @(negedge clk);
        check("rd_valid", rsp_valid, 1);
        check("rd_we", rsp_we, 0);
        check("rd_id", rsp_id, 4);
        check("rd_rdata", rsp_rdata, {16{8'hA5}});
        cyc();
    endtask

    task automatic t_back_to_back();
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, PA_WIDTH'(i << 4), pattern(i), ID_WIDTH'(i));
            cyc();
        end
        drain();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    offer(1'b0, PA_WIDTH'((i << 4) | ($urandom % 16)), '0, ID_WIDTH'(i));
                    cyc();
                end
                idle();
            end
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = rsp_valid;
                end
                check("b2b_first_timeout", seen, 1);
                for (int k = 0; k < 8; k++) begin
                    check("b2b_valid", rsp_valid, 1);
                    check("b2b_id", rsp_id, ID_WIDTH'(k));
                    check("b2b_rdata", rsp_rdata, pattern(k));
                    check("b2b_busy", busy, 1);
                    if (k < 7) @(negedge clk);
                end
            end
        join
        drain();
    endtask

    task automatic t_stall();
        logic [ID_WIDTH-1:0]   id;
        logic                  we;
        logic [LINE_WIDTH-1:0] data;
        bit                    seen = 1'b0;
        offer(1'b0, 32'h20, '0, 4'd2);
        cyc();
        idle();
        rsp_ready = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            seen = rsp_valid;
        end
        check("stall_first_timeout", seen, 1);
        // A second request waits behind the refused response.
        offer(1'b0, 32'h30, '0, 4'd9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_id", rsp_id, 2);
            check("stall_rdata", rsp_rdata, pattern(2));
            check("stall_req_ready", req_ready, 0);
            cyc();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release_id", rsp_id, 2);
        check("release_req_ready", req_ready, 1);
        cyc();
        idle();
        wait_rsp(id, we, data);
        check("after_stall_id", id, 9);
        check("after_stall_rdata", data, pattern(3));
        drain();
    endtask

    task automatic t_alias();
        logic [ID_WIDTH-1:0]   id;
        logic                  we;
        logic [LINE_WIDTH-1:0] data;
        logic [LINE_WIDTH-1:0] d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        offer(1'b1, 32'h1040, d, 4'd5);
        cyc();
        offer(1'b0, 32'h0047, '0, 4'd6);
        cyc();
        idle();
        wait_rsp(id, we, data);
        check("alias_ack_id", id, 5);
        check("alias_ack_we", we, 1);
        wait_rsp(id, we, data);
        check("alias_rd_id", id, 6);
        check("alias_rd_rdata", data, d);
        drain();
    endtask

    task automatic t_reset_mid();
        logic [ID_WIDTH-1:0]   id;
        logic                  we;
        logic [LINE_WIDTH-1:0] data;
        logic [LINE_WIDTH-1:0] d = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
        offer(1'b1, 32'h90, d, 4'd1);
        cyc();
        drain();
        for (int i = 0; i < 3; i++) begin
            offer(1'b0, PA_WIDTH'(i << 4), '0, ID_WIDTH'(10 + i));
            cyc();
        end
        idle();
        cyc();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        offer(1'b0, 32'h90, '0, 4'd13);
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);
        cyc();
        idle();
        wait_rsp(id, we, data);
        check("post_rst_first_id", id, 13);
        check("post_rst_rdata", data, d);
        drain();
    endtask

    task automatic t_random();
        for (int c = 0; c < 800; c++) begin
            rsp_ready = ($urandom % 4) != 0;
            if (($urandom % 4) != 0) begin
                int unsigned idx = $urandom % 16;
                bit          we  = ($urandom % 2 == 1) || !known[idx];
                offer(we, ($urandom & 32'hFFFF_F00F) | PA_WIDTH'(idx << 4),
                      {$urandom, $urandom, $urandom, $urandom}, ID_WIDTH'($urandom));
            end else begin
                idle();
            end
            cyc();
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        check("init_rsp_valid", rsp_valid, 0);
        check("init_busy", busy, 0);
        check("init_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        t_write_then_read();
        drain();
        t_back_to_back();
        t_stall();
        t_alias();
        t_reset_mid();
        t_random();
        @(negedge clk);
        check("final_busy", busy, 0);
        check("final_model_empty", q.size() == 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
